// File: rtl/btn_debounce_sync.sv
// Multi-channel push-button conditioner: 2-flop synchroniser, stability-counter debounce,
// one-cycle rise/fall pulses. Define BTN_DEBOUNCE_LONG_PRESS_EN to add long-press detection.
module btn_debounce_sync #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] db_level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES);
`endif

  typedef enum logic [1:0] {S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK} state_t;

  // Handshake: none. Outputs are plain registered levels/pulses valid every cycle.
  logic [N_CH-1:0] sync_meta;
  logic [N_CH-1:0] sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic          db_r;
    logic          rise_r;
    logic          fall_r;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    logic          long_r;
`endif

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state  <= S_LOW;
        cnt    <= '0;
        db_r   <= 1'b0;
        rise_r <= 1'b0;
        fall_r <= 1'b0;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
        long_r <= 1'b0;
`endif
      end else begin
        rise_r <= 1'b0;
        fall_r <= 1'b0;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
        long_r <= 1'b0;
`endif
        case (state)
          S_LOW: begin
            if (sync[i]) begin
              state <= S_RISE_CHK;
              cnt   <= CW'(1);
            end
          end
          S_RISE_CHK: begin
            if (!sync[i]) begin
              state <= S_LOW;
              cnt   <= '0;
            end else if (cnt < DB_MAX) begin
              cnt <= cnt + CW'(1);
            end else begin
              state  <= S_HIGH;
              db_r   <= 1'b1;
              rise_r <= 1'b1;
              cnt    <= '0;
            end
          end
          S_HIGH: begin
            if (!sync[i]) begin
              state <= S_FALL_CHK;
              cnt   <= CW'(1);
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
            end else if (cnt < LONG_MAX) begin
              // Saturating hold counter: exactly one pulse per press.
              cnt <= cnt + CW'(1);
              if (cnt == LONG_MAX - CW'(1)) long_r <= 1'b1;
`endif
            end
          end
          S_FALL_CHK: begin
            if (sync[i]) begin
              state <= S_HIGH;
              cnt   <= '0;
            end else if (cnt < DB_MAX) begin
              cnt <= cnt + CW'(1);
            end else begin
              state  <= S_LOW;
              db_r   <= 1'b0;
              fall_r <= 1'b1;
              cnt    <= '0;
            end
          end
          default: begin
            state <= S_LOW;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign db_level[i] = db_r;
    assign rise[i]     = rise_r;
    assign fall[i]     = fall_r;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    assign long_press[i] = long_r;
`else
    assign long_press[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_btn_debounce_sync.sv
// Bench for btn_debounce_sync: directed scenarios plus random button activity, checked
// every cycle against a run-length reference model through an expected-value queue.
module tb_btn_debounce_sync;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int L  = 20;
  localparam int W  = 4 * N;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_raw = '1;
  logic [N-1:0] db_level, rise, fall, long_press;

  btn_debounce_sync #(.N_CH(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw),
    .db_level(db_level), .rise(rise), .fall(fall), .long_press(long_press)
  );

  always #5 clock = ~clock;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Reference model: pin seen two edges late; level flips after D+1 consecutive
  // differing samples; long press after L consecutive counted high samples.
  bit m_s1[N], m_s2[N], m_db[N], m_prev[N];
  int m_run[N], m_hold[N];

  always @(posedge clock) begin
    logic [N-1:0] e_db, e_r, e_f, e_lp;
    bit smp, db_before;
    e_db = '0; e_r = '0; e_f = '0; e_lp = '0;
    started = 1;
    for (int c = 0; c < N; c++) begin
      if (reset) begin
        m_s1[c] = 0; m_s2[c] = 0; m_db[c] = 0; m_prev[c] = 0;
        m_run[c] = 0; m_hold[c] = 0;
      end else begin
        smp = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = btn_raw[c];
        db_before = m_db[c];
        if (smp != m_db[c]) begin
          m_run[c]++;
          if (m_run[c] == D + 1) begin
            m_db[c] = smp;
            if (smp) e_r[c] = 1'b1; else e_f[c] = 1'b1;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        if (!smp) m_hold[c] = 0;
        else if (db_before && m_prev[c] && m_hold[c] < L) begin
          m_hold[c]++;
          if (m_hold[c] == L) e_lp[c] = 1'b1;
        end
        m_prev[c] = smp;
      end
      e_db[c] = m_db[c];
    end
`ifndef BTN_DEBOUNCE_LONG_PRESS_EN
    e_lp = '0;
`endif
    exp_q.push_back({e_lp, e_f, e_r, e_db});
  end

  // Monitor: one output word per cycle, compared away from the active edge.
  always @(negedge clock) begin
    logic [W-1:0] exp_v, act_v;
    if (started) begin
      act_v = {long_press, fall, rise, db_level};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL queue_empty t=%0t actual=%h", $time, act_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (reset) exp_v = '0;
        if (act_v !== exp_v) begin
          errors++;
          if (errors <= 30)
            $display("FAIL outputs t=%0t {long,fall,rise,db} actual=%h expected=%h",
                     $time, act_v, exp_v);
        end
      end
    end
  end

  task automatic drive(input logic [N-1:0] v, input int n);
    btn_raw = v;
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  int seg_left[N];
  logic [N-1:0] seg_lvl;

  initial begin
    // Reset with all pins held high, then release: one rise per channel.
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    drive(4'b1111, 12);
    drive(4'b0000, 12);
    // Clean press on ch0.
    drive(4'b0001, 10);
    // Bounce on ch1 never reaches the threshold.
    drive(4'b0011, 3);
    drive(4'b0001, 1);
    drive(4'b0011, 3);
    drive(4'b0001, 10);
    // ch2 debounced high, then release with a one-cycle glitch.
    drive(4'b0101, 10);
    drive(4'b0001, 2);
    drive(4'b0101, 1);
    drive(4'b0001, 12);
    // Simultaneous press on ch0 and ch3, held long enough for a long press.
    drive(4'b0000, 12);
    drive(4'b1001, 30);
    // Release glitch restarts the long-press count.
    drive(4'b0000, 1);
    drive(4'b1001, 28);
    drive(4'b0000, 12);
    // Reset in the middle of a ch1 rise check.
    drive(4'b0010, 4);
    btn_raw = 4'b0000;
    do_reset(2);
    drive(4'b0000, 10);
    // Random segments: short runs bounce, long runs get accepted.
    seg_lvl = '0;
    for (int c = 0; c < N; c++) seg_left[c] = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (seg_left[c] == 0) begin
          seg_lvl[c] = 1'($urandom_range(0, 1));
          seg_left[c] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4)
                                                    : $urandom_range(5, 40);
        end
        seg_left[c]--;
      end
      if ($urandom_range(0, 599) == 0) begin
        btn_raw = seg_lvl;
        do_reset($urandom_range(1, 3));
      end else begin
        drive(seg_lvl, 1);
      end
    end
    drive(4'b0000, 15);
    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
